// File: rtl/pmem_line_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pmem_line_arbiter_pkg
// Description : Shared types and helpers for the physical-memory line arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package pmem_line_arbiter_pkg;

   // Arbiter FSM encoding; width is fixed so the state register is explicit.
   localparam int ARB_STATE_W = 2;

   typedef enum logic [ARB_STATE_W-1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_DONE = 2'd2
   } arb_state_t;

   // Arbitration policy selected by the ARB_MODE parameter.
   typedef enum logic {
      ARB_FIXED = 1'b0,
      ARB_RR    = 1'b1
   } arb_mode_t;

   // Width of a client index; a single client still needs one bit of storage.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : pmem_line_arbiter_pkg
`default_nettype wire

// File: rtl/pmem_line_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : pmem_line_arbiter_rr_picker
// Description : Rotated priority encoder. Returns the first requesting index
//               at or after start_i, searching upward with wrap-around.
//               Tying start_i to zero gives plain lowest-index priority.
// Revision    : 1.0 - initial release
// ============================================================================
module pmem_line_arbiter_rr_picker
   import pmem_line_arbiter_pkg::*;
#(
   parameter int NUM_CLIENTS = 2,
   parameter int IDX_W       = 1
) (
   input  logic [NUM_CLIENTS-1:0] req_i,
   input  logic [IDX_W-1:0]       start_i,
   output logic                   found_o,
   output logic [IDX_W-1:0]       idx_o
);

   // Walk the candidates in rotated order and keep the first one that requests.
   always_comb begin : p_pick
      int         cand_full;
      logic [IDX_W-1:0] cand;
      found_o   = 1'b0;
      idx_o     = '0;
      cand_full = 0;
      cand      = '0;
      for (int k = 0; k < NUM_CLIENTS; k++) begin
         cand_full = int'(start_i) + k;
         if (cand_full >= NUM_CLIENTS) begin
            cand_full = cand_full - NUM_CLIENTS;
         end
         cand = IDX_W'(cand_full);
         if (!found_o && req_i[cand]) begin
            found_o = 1'b1;
            idx_o   = cand;
         end
      end
   end

endmodule : pmem_line_arbiter_rr_picker
`default_nettype wire

// File: rtl/pmem_line_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pmem_line_arbiter
// Description : N-client arbiter in front of the single physical-memory line
//               port. One full-line transfer at a time, with the winner's
//               address, write data and operation latched at grant so that
//               client inputs may change freely while memory is busy.
//               Fixed-priority or round-robin selection.
// Revision    : 1.0 - initial release
// ============================================================================
module pmem_line_arbiter
   import pmem_line_arbiter_pkg::*;
#(
   parameter int NUM_CLIENTS = 2,
   parameter int LINE_WIDTH  = 256,
   parameter int ADDR_WIDTH  = 32,
   parameter int ARB_MODE    = 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_CLIENTS-1:0]            req_read,
   input  logic [NUM_CLIENTS-1:0]            req_write,
   input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_CLIENTS*LINE_WIDTH-1:0] req_wdata,
   output logic [LINE_WIDTH-1:0]             req_rdata,
   output logic [NUM_CLIENTS-1:0]            req_resp,
   output logic                              pmem_read,
   output logic                              pmem_write,
   output logic [ADDR_WIDTH-1:0]             pmem_address,
   output logic [LINE_WIDTH-1:0]             pmem_wdata,
   input  logic [LINE_WIDTH-1:0]             pmem_rdata,
   input  logic                              pmem_resp
);

   localparam int IDX_W = idx_width(NUM_CLIENTS);

   // ------------------------------------------------------------------------
   // State and latch registers
   // ------------------------------------------------------------------------
   arb_state_t             state_q, state_d;
   logic [IDX_W-1:0]       grant_q;
   logic [IDX_W-1:0]       rr_ptr_q;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [LINE_WIDTH-1:0]  wdata_q;
   logic                   op_wr_q;
   logic [LINE_WIDTH-1:0]  rdata_q;

   // ------------------------------------------------------------------------
   // Request selection
   // ------------------------------------------------------------------------
   logic [NUM_CLIENTS-1:0] w_req;
   logic [IDX_W-1:0]       w_start;
   logic                   w_found;
   logic [IDX_W-1:0]       w_win_idx;
   logic [ADDR_WIDTH-1:0]  w_win_addr;
   logic [LINE_WIDTH-1:0]  w_win_wdata;
   logic                   w_win_wr;
   logic [IDX_W-1:0]       w_rr_next;

   // A client is requesting if either op is raised; write dominates later.
   assign w_req = req_read | req_write;

   // Fixed mode always searches from client 0; round-robin from the pointer.
   assign w_start = (ARB_MODE == int'(ARB_RR)) ? rr_ptr_q : '0;

   pmem_line_arbiter_rr_picker #(
      .NUM_CLIENTS (NUM_CLIENTS),
      .IDX_W       (IDX_W)
   ) u_picker (
      .req_i   (w_req),
      .start_i (w_start),
      .found_o (w_found),
      .idx_o   (w_win_idx)
   );

   // Mux out the winner's address, data and operation for latching at grant.
   always_comb begin
      w_win_addr  = '0;
      w_win_wdata = '0;
      w_win_wr    = 1'b0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         if (w_win_idx == IDX_W'(i)) begin
            w_win_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            w_win_wdata = req_wdata[i*LINE_WIDTH +: LINE_WIDTH];
            w_win_wr    = req_write[i];
         end
      end
   end

   // Pointer to the client after the one just served, wrapping at the top.
   always_comb begin
      if (grant_q == IDX_W'(NUM_CLIENTS-1)) begin
         w_rr_next = '0;
      end else begin
         w_rr_next = grant_q + 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------------

   // State register; reset drops any in-flight transfer without a response.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ARB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: grant when anyone asks, hold for memory, then one-cycle done.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE: if (w_found)   state_d = ARB_BUSY;
         ARB_BUSY: if (pmem_resp) state_d = ARB_DONE;
         ARB_DONE:                state_d = ARB_IDLE;
         default:                 state_d = ARB_IDLE;
      endcase
   end

   // Outputs: memory strobes only while busy, client response only when done.
   always_comb begin
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      req_resp   = '0;
      if (state_q == ARB_BUSY) begin
         pmem_read  = ~op_wr_q;
         pmem_write =  op_wr_q;
      end
      if (state_q == ARB_DONE) begin
         for (int i = 0; i < NUM_CLIENTS; i++) begin
            req_resp[i] = (grant_q == IDX_W'(i));
         end
      end
   end

   // Address and data always come from the latches, never from live inputs.
   assign pmem_address = addr_q;
   assign pmem_wdata   = wdata_q;
   assign req_rdata    = rdata_q;

   // ------------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------------

   // Latch the winner at grant, capture read data on completion, advance RR.
   always_ff @(posedge clk) begin
      if (!rst) begin
         grant_q  <= '0;
         rr_ptr_q <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         op_wr_q  <= 1'b0;
         rdata_q  <= '0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (w_found) begin
                  grant_q <= w_win_idx;
                  addr_q  <= w_win_addr;
                  wdata_q <= w_win_wdata;
                  op_wr_q <= w_win_wr;
               end
            end
            ARB_BUSY: begin
               if (pmem_resp && !op_wr_q) begin
                  rdata_q <= pmem_rdata;
               end
            end
            ARB_DONE: begin
               if (ARB_MODE == int'(ARB_RR)) begin
                  rr_ptr_q <= w_rr_next;
               end
            end
            default: ;
         endcase
      end
   end

endmodule : pmem_line_arbiter
`default_nettype wire

// File: tb/tb_pmem_line_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pmem_line_arbiter
// Description : Directed self-checking bench. Instance A is a 4-client
//               round-robin arbiter, instance B a 2-client fixed-priority one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pmem_line_arbiter;

   localparam int LW = 256;
   localparam int AW = 32;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   // Instance A: 4 clients, round-robin
   logic [3:0]      a_req_read, a_req_write;
   logic [4*AW-1:0] a_req_addr;
   logic [4*LW-1:0] a_req_wdata;
   logic [LW-1:0]   a_req_rdata;
   logic [3:0]      a_req_resp;
   logic            a_pmem_read, a_pmem_write;
   logic [AW-1:0]   a_pmem_address;
   logic [LW-1:0]   a_pmem_wdata;
   logic [LW-1:0]   a_pmem_rdata;
   logic            a_pmem_resp;

   // Instance B: 2 clients, fixed priority
   logic [1:0]      b_req_read, b_req_write;
   logic [2*AW-1:0] b_req_addr;
   logic [2*LW-1:0] b_req_wdata;
   logic [LW-1:0]   b_req_rdata;
   logic [1:0]      b_req_resp;
   logic            b_pmem_read, b_pmem_write;
   logic [AW-1:0]   b_pmem_address;
   logic [LW-1:0]   b_pmem_wdata;
   logic [LW-1:0]   b_pmem_rdata;
   logic            b_pmem_resp;

   pmem_line_arbiter #(
      .NUM_CLIENTS (4), .LINE_WIDTH (LW), .ADDR_WIDTH (AW), .ARB_MODE (1)
   ) u_dut_rr (
      .clk (clk), .rst (rst),
      .req_read (a_req_read), .req_write (a_req_write),
      .req_addr (a_req_addr), .req_wdata (a_req_wdata),
      .req_rdata (a_req_rdata), .req_resp (a_req_resp),
      .pmem_read (a_pmem_read), .pmem_write (a_pmem_write),
      .pmem_address (a_pmem_address), .pmem_wdata (a_pmem_wdata),
      .pmem_rdata (a_pmem_rdata), .pmem_resp (a_pmem_resp)
   );

   pmem_line_arbiter #(
      .NUM_CLIENTS (2), .LINE_WIDTH (LW), .ADDR_WIDTH (AW), .ARB_MODE (0)
   ) u_dut_fix (
      .clk (clk), .rst (rst),
      .req_read (b_req_read), .req_write (b_req_write),
      .req_addr (b_req_addr), .req_wdata (b_req_wdata),
      .req_rdata (b_req_rdata), .req_resp (b_req_resp),
      .pmem_read (b_pmem_read), .pmem_write (b_pmem_write),
      .pmem_address (b_pmem_address), .pmem_wdata (b_pmem_wdata),
      .pmem_rdata (b_pmem_rdata), .pmem_resp (b_pmem_resp)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hard stop if the directed sequence ever stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [LW-1:0] line_a5, line_1234, last_rd;
      logic [3:0]    exp_oh;
      int            ord[5];
      int            idle;

      line_a5   = {32{8'hA5}};
      line_1234 = {16{16'h1234}};
      ord       = '{0, 1, 2, 3, 0};

      rst = 1'b0;
      a_req_read = '0; a_req_write = '0; a_req_addr = '0; a_req_wdata = '0;
      a_pmem_rdata = '0; a_pmem_resp = 1'b0;
      b_req_read = '0; b_req_write = '0; b_req_addr = '0; b_req_wdata = '0;
      b_pmem_rdata = '0; b_pmem_resp = 1'b0;
      tick(); tick();

      // Reset state
      chk("rst_a_read",  a_pmem_read, 1'b0);
      chk("rst_a_write", a_pmem_write, 1'b0);
      chk("rst_a_resp",  a_req_resp, 4'b0000);
      chk("rst_a_addr",  a_pmem_address, 32'h0);
      chk("rst_a_rdata", a_req_rdata, '0);
      chk("rst_b_read",  b_pmem_read, 1'b0);
      chk("rst_b_resp",  b_req_resp, 2'b00);
      rst = 1'b1;
      tick();

      // 1. Single read by client 0
      a_req_addr[31:0] = 32'h0000_1240;
      a_req_read[0]    = 1'b1;
      tick();
      chk("t1_pmem_read",  a_pmem_read, 1'b1);
      chk("t1_pmem_write", a_pmem_write, 1'b0);
      chk("t1_addr",       a_pmem_address, 32'h0000_1240);
      chk("t1_no_resp",    a_req_resp, 4'b0000);
      repeat (5) tick();
      chk("t1_hold",       a_pmem_read, 1'b1);
      a_pmem_resp  = 1'b1;
      a_pmem_rdata = line_a5;
      tick();
      a_pmem_resp  = 1'b0;
      a_pmem_rdata = '0;
      chk("t1_resp",       a_req_resp, 4'b0001);
      chk("t1_rdata",      a_req_rdata, line_a5);
      chk("t1_done_read",  a_pmem_read, 1'b0);
      a_req_read = '0;
      tick();
      chk("t1_resp_pulse", a_req_resp, 4'b0000);

      // Stray memory response while idle is ignored
      a_pmem_resp  = 1'b1;
      a_pmem_rdata = {32{8'h5A}};
      tick();
      a_pmem_resp  = 1'b0;
      chk("idle_resp",  a_req_resp, 4'b0000);
      chk("idle_rdata", a_req_rdata, line_a5);
      chk("idle_read",  a_pmem_read, 1'b0);

      // 2. All four clients request, round-robin order 0,1,2,3,0
      rst = 1'b0; tick(); rst = 1'b1;
      for (int i = 0; i < 4; i++) a_req_addr[i*AW +: AW] = 32'h0001_0000 + i * 32'h100;
      a_req_read = 4'hF;
      for (int t = 0; t < 5; t++) begin
         tick();
         chk("t2_addr", a_pmem_address, 32'h0001_0000 + ord[t] * 32'h100);
         chk("t2_read", a_pmem_read, 1'b1);
         a_pmem_resp  = 1'b1;
         a_pmem_rdata = {8{32'hC0DE_0000 + t}};
         tick();
         a_pmem_resp  = 1'b0;
         exp_oh = 4'b0001 << ord[t];
         chk("t2_resp",  a_req_resp, exp_oh);
         chk("t2_rdata", a_req_rdata, {8{32'hC0DE_0000 + t}});
         idle = 0;
         if (!a_pmem_read && !a_pmem_write) idle++;
         tick();
         if (!a_pmem_read && !a_pmem_write) idle++;
         chk("t2_resp_clr", a_req_resp, 4'b0000);
         chk("t2_gap", idle, 2);
      end
      a_req_read = '0;
      last_rd = {8{32'hC0DE_0004}};

      // 4. Write by client 1 with input churn after grant
      a_req_addr[63:32]   = 32'h0000_8000;
      a_req_wdata[511:256] = line_1234;
      a_req_write[1]      = 1'b1;
      tick();
      chk("t4_write", a_pmem_write, 1'b1);
      chk("t4_read",  a_pmem_read, 1'b0);
      chk("t4_addr0", a_pmem_address, 32'h0000_8000);
      chk("t4_data0", a_pmem_wdata, line_1234);
      a_req_addr[63:32]    = '1;
      a_req_wdata[511:256] = '1;
      tick();
      chk("t4_addr1", a_pmem_address, 32'h0000_8000);
      chk("t4_data1", a_pmem_wdata, line_1234);
      tick();
      chk("t4_addr2", a_pmem_address, 32'h0000_8000);
      chk("t4_data2", a_pmem_wdata, line_1234);
      a_pmem_resp  = 1'b1;
      a_pmem_rdata = '1;
      tick();
      a_pmem_resp  = 1'b0;
      a_pmem_rdata = '0;
      chk("t4_resp",       a_req_resp, 4'b0010);
      chk("t4_rdata_kept", a_req_rdata, last_rd);
      a_req_write = '0;
      tick();

      // 5. Read and write both raised on client 0: write wins
      a_req_addr[31:0] = 32'h0000_4440;
      a_req_read[0]    = 1'b1;
      a_req_write[0]   = 1'b1;
      tick();
      chk("t5_write", a_pmem_write, 1'b1);
      chk("t5_read",  a_pmem_read, 1'b0);
      a_pmem_resp = 1'b1;
      tick();
      a_pmem_resp = 1'b0;
      chk("t5_resp", a_req_resp, 4'b0001);
      a_req_read = '0; a_req_write = '0;
      tick();

      // 6. Reset in the middle of a read
      a_req_addr[31:0] = 32'h0000_5000;
      a_req_read[0]    = 1'b1;
      tick();
      chk("t6_busy", a_pmem_read, 1'b1);
      rst = 1'b0;
      tick();
      chk("t6_read_rst", a_pmem_read, 1'b0);
      chk("t6_resp_rst", a_req_resp, 4'b0000);
      rst = 1'b1;
      a_req_read  = '0;
      a_pmem_resp = 1'b1;
      tick();
      a_pmem_resp = 1'b0;
      chk("t6_late_resp", a_req_resp, 4'b0000);
      chk("t6_idle_read", a_pmem_read, 1'b0);
      tick();
      chk("t6_no_resp", a_req_resp, 4'b0000);
      // Pointer back at 0: with everyone requesting, client 0 wins first
      a_req_addr[63:32] = 32'h0001_0100;
      a_req_read = 4'hF;
      tick();
      chk("t6_rr_first", a_pmem_address, 32'h0000_5000);
      a_pmem_resp = 1'b1;
      tick();
      a_pmem_resp = 1'b0;
      chk("t6_rr_resp", a_req_resp, 4'b0001);
      a_req_read = '0;
      tick();

      // 3. Fixed priority: client 1 waits until client 0 drops
      b_req_addr = {32'h0000_B100, 32'h0000_B000};
      b_req_read = 2'b11;
      for (int t = 0; t < 3; t++) begin
         tick();
         chk("t3_addr_c0", b_pmem_address, 32'h0000_B000);
         chk("t3_read",    b_pmem_read, 1'b1);
         b_pmem_resp = 1'b1;
         tick();
         b_pmem_resp = 1'b0;
         chk("t3_resp_c0", b_req_resp, 2'b01);
         if (t == 2) b_req_read = 2'b10;
         tick();
      end
      tick();
      chk("t3_addr_c1", b_pmem_address, 32'h0000_B100);
      b_pmem_resp = 1'b1;
      tick();
      b_pmem_resp = 1'b0;
      chk("t3_resp_c1", b_req_resp, 2'b10);
      b_req_read = '0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_pmem_line_arbiter
`default_nettype wire
